// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Shares the CPU's single memory bus between three masters:
//   m0 = instruction fetch, m1 = load/store, m2 = auxiliary (DMA / video).
// A two-state FSM (IDLE/BUSY) picks one requester in IDLE and registers its
// index into O_grant. While BUSY, the granted master's request and bus fields
// are steered onto the shared bus. The bus acknowledge is routed back to that
// master only. A grant ends on acknowledge or when the master drops its
// request (abort). One IDLE cycle always separates two grants.
//
// Configuration macro:
//   BUS_ARBITER_ROUNDROBIN_EN  defined   -> round-robin selection; the search
//                                           starts after the last granted master.
//                              undefined -> fixed priority m0 > m1 > m2.
//
// Parameters:
//   ADDR_WIDTH  address width (default 32)
//   DATA_WIDTH  data width (default 32); byte-select width is DATA_WIDTH/8
//
// Ports:
//   I_clk, I_reset           clock, synchronous active-high reset
//   I_mX_req/we/addr/data/sel  per-master request and bus fields (X = 0..2)
//   O_mX_ack                 per-master acknowledge (only the granted master)
//   O_mX_data                per-master read data (I_data broadcast)
//   O_stb/we/addr/data/sel   shared-bus outputs muxed from the granted master
//   I_ack, I_data            shared-bus acknowledge and read data
//   O_grant                  registered grant index (0..2)
//   O_busy                   high while a grant is held
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    I_clk,
  input  logic                    I_reset,

  input  logic                    I_m0_req,
  input  logic                    I_m0_we,
  input  logic [ADDR_WIDTH-1:0]   I_m0_addr,
  input  logic [DATA_WIDTH-1:0]   I_m0_data,
  input  logic [DATA_WIDTH/8-1:0] I_m0_sel,
  output logic                    O_m0_ack,
  output logic [DATA_WIDTH-1:0]   O_m0_data,

  input  logic                    I_m1_req,
  input  logic                    I_m1_we,
  input  logic [ADDR_WIDTH-1:0]   I_m1_addr,
  input  logic [DATA_WIDTH-1:0]   I_m1_data,
  input  logic [DATA_WIDTH/8-1:0] I_m1_sel,
  output logic                    O_m1_ack,
  output logic [DATA_WIDTH-1:0]   O_m1_data,

  input  logic                    I_m2_req,
  input  logic                    I_m2_we,
  input  logic [ADDR_WIDTH-1:0]   I_m2_addr,
  input  logic [DATA_WIDTH-1:0]   I_m2_data,
  input  logic [DATA_WIDTH/8-1:0] I_m2_sel,
  output logic                    O_m2_ack,
  output logic [DATA_WIDTH-1:0]   O_m2_data,

  output logic                    O_stb,
  output logic                    O_we,
  output logic [ADDR_WIDTH-1:0]   O_addr,
  output logic [DATA_WIDTH-1:0]   O_data,
  output logic [DATA_WIDTH/8-1:0] O_sel,
  input  logic                    I_ack,
  input  logic [DATA_WIDTH-1:0]   I_data,

  output logic [1:0]              O_grant,
  output logic                    O_busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] grant_q;
  logic [1:0] grant_next;
  logic [1:0] last_ptr;
  logic [1:0] last_ptr_next;

  logic [2:0] req_vec;
  logic [1:0] winner;
  logic       granted_req;

  assign req_vec = {I_m2_req, I_m1_req, I_m0_req};

  // Request of whichever master currently holds the grant. Index 3 never
  // occurs; it reads as "no request" so the FSM would fall back to IDLE.
  always_comb begin
    granted_req = 1'b0;
    case (grant_q)
      2'd0:    granted_req = I_m0_req;
      2'd1:    granted_req = I_m1_req;
      2'd2:    granted_req = I_m2_req;
      default: granted_req = 1'b0;
    endcase
  end

`ifdef BUS_ARBITER_ROUNDROBIN_EN
  // Round-robin: the search starts one past the last granted master and
  // wraps. last_ptr resets to 2 so the very first search order is m0, m1, m2.
  always_comb begin
    winner = 2'd0;
    case (last_ptr)
      2'd0: begin
        if      (req_vec[1]) winner = 2'd1;
        else if (req_vec[2]) winner = 2'd2;
        else                 winner = 2'd0;
      end
      2'd1: begin
        if      (req_vec[2]) winner = 2'd2;
        else if (req_vec[0]) winner = 2'd0;
        else                 winner = 2'd1;
      end
      default: begin
        if      (req_vec[0]) winner = 2'd0;
        else if (req_vec[1]) winner = 2'd1;
        else                 winner = 2'd2;
      end
    endcase
  end
`else
  // Fixed priority: instruction fetch first, then load/store, then the
  // auxiliary master. last_ptr is still tracked but nothing reads it here.
  always_comb begin
    winner = 2'd0;
    if      (req_vec[0]) winner = 2'd0;
    else if (req_vec[1]) winner = 2'd1;
    else if (req_vec[2]) winner = 2'd2;
  end
`endif

  // State register: FSM state, registered grant index and last-grant pointer.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state    <= IDLE;
      grant_q  <= 2'd0;
      last_ptr <= 2'd2;
    end else begin
      state    <= state_next;
      grant_q  <= grant_next;
      last_ptr <= last_ptr_next;
    end
  end

  // Next-state logic. A grant ends either on the bus acknowledge or when the
  // granted master withdraws its request; both return to IDLE, which gives
  // the mandatory turnaround cycle before the next grant. Requests seen in
  // the BUSY cycle are not remembered: they are re-evaluated in IDLE.
  always_comb begin
    state_next    = state;
    grant_next    = grant_q;
    last_ptr_next = last_ptr;
    case (state)
      IDLE: begin
        if (|req_vec) begin
          state_next = BUSY;
          grant_next = winner;
        end
      end
      BUSY: begin
        if (I_ack || !granted_req) begin
          state_next    = IDLE;
          last_ptr_next = grant_q;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic. The strobe follows the granted master's request so an
  // abort drops it in the same cycle. Acks are qualified by that request so
  // a master that has just aborted never sees an acknowledge, and a stray
  // I_ack in IDLE produces nothing.
  always_comb begin
    O_stb    = 1'b0;
    O_we     = 1'b0;
    O_addr   = '0;
    O_data   = '0;
    O_sel    = '0;
    O_m0_ack = 1'b0;
    O_m1_ack = 1'b0;
    O_m2_ack = 1'b0;
    if (state == BUSY) begin
      O_stb = granted_req;
      case (grant_q)
        2'd0: begin
          O_we     = I_m0_we;
          O_addr   = I_m0_addr;
          O_data   = I_m0_data;
          O_sel    = I_m0_sel;
          O_m0_ack = I_ack & granted_req;
        end
        2'd1: begin
          O_we     = I_m1_we;
          O_addr   = I_m1_addr;
          O_data   = I_m1_data;
          O_sel    = I_m1_sel;
          O_m1_ack = I_ack & granted_req;
        end
        2'd2: begin
          O_we     = I_m2_we;
          O_addr   = I_m2_addr;
          O_data   = I_m2_data;
          O_sel    = I_m2_sel;
          O_m2_ack = I_ack & granted_req;
        end
        default: begin
          O_we = 1'b0;
        end
      endcase
    end
  end

  // Read data is broadcast; each master only trusts it in its ack cycle.
  assign O_m0_data = I_data;
  assign O_m1_data = I_data;
  assign O_m2_data = I_data;

  assign O_grant = grant_q;
  assign O_busy  = (state == BUSY);

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter. Inputs change 1 time unit after the
// rising edge and outputs are compared on the falling edge. A table of
// per-cycle vectors covers single read/write transactions, simultaneous
// requests and a stray acknowledge; hand-written sequences cover continuous
// contention, abort and reset in the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic        I_clk;
  logic        I_reset;
  logic        I_m0_req, I_m1_req, I_m2_req;
  logic        I_m0_we, I_m1_we, I_m2_we;
  logic [31:0] I_m0_addr, I_m1_addr, I_m2_addr;
  logic [31:0] I_m0_data, I_m1_data, I_m2_data;
  logic [3:0]  I_m0_sel, I_m1_sel, I_m2_sel;
  logic        O_m0_ack, O_m1_ack, O_m2_ack;
  logic [31:0] O_m0_data, O_m1_data, O_m2_data;
  logic        O_stb, O_we;
  logic [31:0] O_addr, O_data;
  logic [3:0]  O_sel;
  logic        I_ack;
  logic [31:0] I_data;
  logic [1:0]  O_grant;
  logic        O_busy;

  int checkCount = 0;
  int passCount  = 0;

  bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .I_clk(I_clk), .I_reset(I_reset),
    .I_m0_req(I_m0_req), .I_m0_we(I_m0_we), .I_m0_addr(I_m0_addr),
    .I_m0_data(I_m0_data), .I_m0_sel(I_m0_sel), .O_m0_ack(O_m0_ack), .O_m0_data(O_m0_data),
    .I_m1_req(I_m1_req), .I_m1_we(I_m1_we), .I_m1_addr(I_m1_addr),
    .I_m1_data(I_m1_data), .I_m1_sel(I_m1_sel), .O_m1_ack(O_m1_ack), .O_m1_data(O_m1_data),
    .I_m2_req(I_m2_req), .I_m2_we(I_m2_we), .I_m2_addr(I_m2_addr),
    .I_m2_data(I_m2_data), .I_m2_sel(I_m2_sel), .O_m2_ack(O_m2_ack), .O_m2_data(O_m2_data),
    .O_stb(O_stb), .O_we(O_we), .O_addr(O_addr), .O_data(O_data), .O_sel(O_sel),
    .I_ack(I_ack), .I_data(I_data),
    .O_grant(O_grant), .O_busy(O_busy)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [2:0]  req;
    logic        ack;
    logic [31:0] rdata;
    logic        chkGrant;
    logic [1:0]  grant;
    logic        stb;
    logic        busy;
    logic [2:0]  acks;
    logic        chkBus;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  // Drive the per-cycle inputs; master bus fields are fixed for the whole run.
  task automatic applyStimulus(input logic [2:0] req, input logic ack, input logic [31:0] rdata);
    {I_m2_req, I_m1_req, I_m0_req} = req;
    I_ack  = ack;
    I_data = rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic doReset();
    I_reset = 1'b1;
    applyStimulus(3'b000, 1'b0, 32'h0);
    tick();
    tick();
    I_reset = 1'b0;
  endtask

  function automatic logic [2:0] ackVec();
    return {O_m2_ack, O_m1_ack, O_m0_ack};
  endfunction

  initial begin
    logic [1:0] expGrants [6];

    I_reset = 1'b0;
    I_m0_we = 1'b0; I_m0_addr = 32'h0000_0100; I_m0_data = 32'hA0A0_A0A0; I_m0_sel = 4'h1;
    I_m1_we = 1'b0; I_m1_addr = 32'h0000_1000; I_m1_data = 32'h1111_1111; I_m1_sel = 4'h3;
    I_m2_we = 1'b1; I_m2_addr = 32'h0000_2000; I_m2_data = 32'h1234_5678; I_m2_sel = 4'hF;
    applyStimulus(3'b000, 1'b0, 32'h0);

    //              req     ack  rdata          cg grant stb busy acks  cb addr           we  wdata          sel
    vecs[0]  = '{3'b010, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,      1'b0, 32'h0,        4'h0};
    vecs[1]  = '{3'b010, 1'b0, 32'h0,        1'b1, 2'd1, 1'b1, 1'b1, 3'b000, 1'b1, 32'h1000,   1'b0, 32'h1111_1111, 4'h3};
    vecs[2]  = '{3'b010, 1'b1, 32'hDEADBEEF, 1'b1, 2'd1, 1'b1, 1'b1, 3'b010, 1'b1, 32'h1000,   1'b0, 32'h1111_1111, 4'h3};
    vecs[3]  = '{3'b000, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,      1'b0, 32'h0,        4'h0};
    vecs[4]  = '{3'b000, 1'b1, 32'h0BAD_0BAD, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,     1'b0, 32'h0,        4'h0};
    vecs[5]  = '{3'b100, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,      1'b0, 32'h0,        4'h0};
    vecs[6]  = '{3'b100, 1'b0, 32'h0,        1'b1, 2'd2, 1'b1, 1'b1, 3'b000, 1'b1, 32'h2000,   1'b1, 32'h1234_5678, 4'hF};
    vecs[7]  = '{3'b100, 1'b1, 32'hCAFE_F00D, 1'b1, 2'd2, 1'b1, 1'b1, 3'b100, 1'b1, 32'h2000,  1'b1, 32'h1234_5678, 4'hF};
    vecs[8]  = '{3'b000, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,      1'b0, 32'h0,        4'h0};
    vecs[9]  = '{3'b011, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,      1'b0, 32'h0,        4'h0};
    vecs[10] = '{3'b011, 1'b0, 32'h0,        1'b1, 2'd0, 1'b1, 1'b1, 3'b000, 1'b1, 32'h100,    1'b0, 32'hA0A0_A0A0, 4'h1};
    vecs[11] = '{3'b011, 1'b1, 32'h55AA_55AA, 1'b1, 2'd0, 1'b1, 1'b1, 3'b001, 1'b1, 32'h100,   1'b0, 32'hA0A0_A0A0, 4'h1};
    vecs[12] = '{3'b010, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,      1'b0, 32'h0,        4'h0};
    vecs[13] = '{3'b010, 1'b0, 32'h0,        1'b1, 2'd1, 1'b1, 1'b1, 3'b000, 1'b1, 32'h1000,   1'b0, 32'h1111_1111, 4'h3};
    vecs[14] = '{3'b010, 1'b1, 32'h7777_0000, 1'b1, 2'd1, 1'b1, 1'b1, 3'b010, 1'b1, 32'h1000,  1'b0, 32'h1111_1111, 4'h3};
    vecs[15] = '{3'b000, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,      1'b0, 32'h0,        4'h0};

    @(posedge I_clk);
    #1;

    // Reset state
    doReset();
    @(negedge I_clk);
    checkOutput("reset_grant", 32'(O_grant), 32'd0);
    checkOutput("reset_busy",  32'(O_busy),  32'd0);
    checkOutput("reset_stb",   32'(O_stb),   32'd0);
    checkOutput("reset_acks",  32'(ackVec()), 32'd0);
    tick();

    // Table-driven single transactions
    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].req, vecs[i].ack, vecs[i].rdata);
      @(negedge I_clk);
      if (vecs[i].chkGrant) checkOutput($sformatf("v%0d_grant", i), 32'(O_grant), 32'(vecs[i].grant));
      checkOutput($sformatf("v%0d_stb", i),  32'(O_stb),  32'(vecs[i].stb));
      checkOutput($sformatf("v%0d_busy", i), 32'(O_busy), 32'(vecs[i].busy));
      checkOutput($sformatf("v%0d_acks", i), 32'(ackVec()), 32'(vecs[i].acks));
      if (vecs[i].chkBus) begin
        checkOutput($sformatf("v%0d_addr", i),  O_addr,     vecs[i].addr);
        checkOutput($sformatf("v%0d_we", i),    32'(O_we),  32'(vecs[i].we));
        checkOutput($sformatf("v%0d_wdata", i), O_data,     vecs[i].wdata);
        checkOutput($sformatf("v%0d_sel", i),   32'(O_sel), 32'(vecs[i].sel));
      end
      if (vecs[i].acks != 3'b000) begin
        checkOutput($sformatf("v%0d_m0data", i), O_m0_data, vecs[i].rdata);
        checkOutput($sformatf("v%0d_m1data", i), O_m1_data, vecs[i].rdata);
        checkOutput($sformatf("v%0d_m2data", i), O_m2_data, vecs[i].rdata);
      end
      tick();
    end

    // Continuous contention, bus ack one cycle after strobe
    $display("[TB] continuous contention");
`ifdef BUS_ARBITER_ROUNDROBIN_EN
    expGrants = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
`else
    expGrants = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(3'b111, 1'b0, 32'h0);
      @(negedge I_clk);
      checkOutput($sformatf("cont%0d_idle_busy", k), 32'(O_busy), 32'd0);
      tick();
      @(negedge I_clk);
      checkOutput($sformatf("cont%0d_grant", k), 32'(O_grant), 32'(expGrants[k]));
      checkOutput($sformatf("cont%0d_stb", k),   32'(O_stb),   32'd1);
      tick();
      applyStimulus(3'b111, 1'b1, 32'h1000 + 32'(k));
      @(negedge I_clk);
      checkOutput($sformatf("cont%0d_acks", k), 32'(ackVec()), 32'(3'b001 << expGrants[k]));
      tick();
    end

    // Abort: m0 drops its request before any ack
    $display("[TB] abort");
    doReset();
    applyStimulus(3'b001, 1'b0, 32'h0);
    tick();
    @(negedge I_clk);
    checkOutput("abort_grant", 32'(O_grant), 32'd0);
    checkOutput("abort_stb_before", 32'(O_stb), 32'd1);
    tick();
    applyStimulus(3'b000, 1'b0, 32'h0);
    @(negedge I_clk);
    checkOutput("abort_stb_same_cycle", 32'(O_stb), 32'd0);
    checkOutput("abort_acks", 32'(ackVec()), 32'd0);
    tick();
    @(negedge I_clk);
    checkOutput("abort_idle_busy", 32'(O_busy), 32'd0);
    tick();
    applyStimulus(3'b000, 1'b1, 32'h1);
    @(negedge I_clk);
    checkOutput("abort_stray_acks", 32'(ackVec()), 32'd0);
    checkOutput("abort_stray_stb", 32'(O_stb), 32'd0);
    tick();

    // Reset while m1 is granted; an m0 transaction first moves the pointer
    $display("[TB] reset mid-transaction");
    doReset();
    applyStimulus(3'b001, 1'b0, 32'h0);
    tick();
    applyStimulus(3'b001, 1'b1, 32'h0);
    tick();
    applyStimulus(3'b010, 1'b0, 32'h0);
    tick();
    @(negedge I_clk);
    checkOutput("midrst_grant_before", 32'(O_grant), 32'd1);
    checkOutput("midrst_busy_before",  32'(O_busy),  32'd1);
    I_reset = 1'b1;
    tick();
    I_reset = 1'b0;
    applyStimulus(3'b011, 1'b0, 32'h0);
    @(negedge I_clk);
    checkOutput("midrst_stb",   32'(O_stb),   32'd0);
    checkOutput("midrst_busy",  32'(O_busy),  32'd0);
    checkOutput("midrst_grant", 32'(O_grant), 32'd0);
    checkOutput("midrst_acks",  32'(ackVec()), 32'd0);
    tick();
    @(negedge I_clk);
    checkOutput("midrst_next_grant", 32'(O_grant), 32'd0);
    checkOutput("midrst_next_stb",   32'(O_stb),   32'd1);
    tick();
    applyStimulus(3'b000, 1'b0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
